// File: rtl/vec_sweep.sv
// vec_sweep: exhaustive 3-input sweep of a combinational stage.
// Drives {a,b,c} through 0..7, holds each vector HOLD_CYCLES cycles,
// samples y at the end of each hold, and compares against EXPECT.
module vec_sweep #(
    parameter int          HOLD_CYCLES = 1,
    parameter logic [7:0]  EXPECT      = 8'hF8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] idx;
    logic [3:0] hcnt;
    logic       hold_end;
    logic       miss;
    logic [3:0] err_nxt;

    // The sample point for the current vector is the last cycle of its hold.
    assign hold_end = (state == DRIVE) && (hcnt == HOLD_LAST);
    assign miss     = (y != EXPECT[idx]);
    assign err_nxt  = err_count + {3'b000, miss};

    // Stimulus and status are decoded from registered state only, so there
    // is no combinational path from y or start to the outputs.
    assign {a, b, c} = (state == DRIVE) ? idx : 3'b000;
    assign busy      = (state == DRIVE);
    assign done      = (state == DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start is only honoured from IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = DRIVE;
            DRIVE:   if (hold_end && (idx == 3'd7)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Sweep datapath: vector index, hold counter, capture and mismatch count.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= 3'd0;
            hcnt      <= 4'd0;
            err_count <= 4'd0;
            result    <= 8'h00;
            pass      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx       <= 3'd0;
                        hcnt      <= 4'd0;
                        err_count <= 4'd0;
                        result    <= 8'h00;
                        pass      <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (hcnt == HOLD_LAST) begin
                        result[idx] <= y;
                        err_count   <= err_nxt;
                        hcnt        <= 4'd0;
                        if (idx != 3'd7) begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        hcnt <= hcnt + 4'd1;
                    end
                end
                DONE: begin
                    // err_count already includes the vector-7 compare here.
                    pass <= (err_count == 4'd0);
                    idx  <= 3'd0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
